// File: rtl/nios_dbg_scan_master.sv
// Debug-slave scan master: runs one IR update plus a DR scan per command.
// It returns the bits captured from tdo and the ir_out status.
module nios_dbg_scan_master #(
  parameter int SR_WIDTH    = 38,
  parameter int IDLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic [1:0]          rsp_ir,
  output logic [1:0]          ir_in,
  input  logic [1:0]          ir_out,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti,
  output logic                tdi,
  input  logic                tdo
);

  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, RSP} state_t;

  localparam logic [6:0] BIT_LAST = 7'(SR_WIDTH - 1);
  localparam logic [7:0] RTI_LAST = 8'((IDLE_CYCLES == 0) ? 0 : IDLE_CYCLES - 1);

  state_t              state;
  logic [SR_WIDTH-1:0] shift;
  logic [6:0]          bit_cnt;
  logic [7:0]          rti_cnt;

  // The shift register doubles as the response buffer; it is frozen in RSP.
  assign rsp_data = shift;

  // All outputs are registered and set on the edge that enters their state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      shift          <= '0;
      rsp_ir         <= 2'b00;
      ir_in          <= 2'b00;
      tdi            <= 1'b0;
      vs_uir         <= 1'b0;
      vs_cdr         <= 1'b0;
      vs_sdr         <= 1'b0;
      vs_udr         <= 1'b0;
      jtag_state_rti <= 1'b1;
      bit_cnt        <= '0;
      rti_cnt        <= '0;
    end else begin
      vs_uir <= 1'b0;
      vs_cdr <= 1'b0;
      vs_sdr <= 1'b0;
      vs_udr <= 1'b0;
      tdi    <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state          <= UIR;
            cmd_ready      <= 1'b0;
            jtag_state_rti <= 1'b0;
            ir_in          <= cmd_ir;
            shift          <= cmd_data;
            bit_cnt        <= '0;
            vs_uir         <= 1'b1;
          end
        end
        UIR: begin
          state  <= CDR;
          vs_cdr <= 1'b1;
        end
        CDR: begin
          state   <= SDR;
          rsp_ir  <= ir_out;
          vs_sdr  <= 1'b1;
          tdi     <= shift[0];
          bit_cnt <= '0;
        end
        SDR: begin
          shift   <= {tdo, shift[SR_WIDTH-1:1]};
          bit_cnt <= bit_cnt + 7'd1;
          if (bit_cnt == BIT_LAST) begin
            state  <= UDR;
            vs_udr <= 1'b1;
          end else begin
            vs_sdr <= 1'b1;
            // shift[1] becomes shift[0] on this same edge
            tdi    <= shift[1];
          end
        end
        UDR: begin
          if (IDLE_CYCLES == 0) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
          end else begin
            state          <= RTI;
            jtag_state_rti <= 1'b1;
            rti_cnt        <= '0;
          end
        end
        RTI: begin
          rti_cnt <= rti_cnt + 8'd1;
          if (rti_cnt == RTI_LAST) begin
            state          <= RSP;
            jtag_state_rti <= 1'b0;
            rsp_valid      <= 1'b1;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            state          <= IDLE;
            rsp_valid      <= 1'b0;
            cmd_ready      <= 1'b1;
            jtag_state_rti <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_dbg_scan_master.sv
// Directed bench for nios_dbg_scan_master: a default-sized instance with tdo
// looped back through one register, and a 2-bit, no-idle instance with tdo=1.
module tb_nios_dbg_scan_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          checks = 0;
  int          errors = 0;

  logic        a_cmd_valid = 1'b0, a_cmd_ready, a_rsp_valid, a_rsp_ready = 1'b0;
  logic [1:0]  a_cmd_ir = 2'b00, a_rsp_ir, a_ir_in, a_ir_out = 2'b00;
  logic [37:0] a_cmd_data = '0, a_rsp_data;
  logic        a_vs_uir, a_vs_cdr, a_vs_sdr, a_vs_udr, a_rti, a_tdi, a_tdo = 1'b0;

  logic        b_cmd_valid = 1'b0, b_cmd_ready, b_rsp_valid, b_rsp_ready = 1'b0;
  logic [1:0]  b_cmd_ir = 2'b00, b_rsp_ir, b_ir_in, b_ir_out = 2'b00;
  logic [1:0]  b_cmd_data = '0, b_rsp_data;
  logic        b_vs_uir, b_vs_cdr, b_vs_sdr, b_vs_udr, b_rti, b_tdi;
  logic        b_tdo = 1'b1;

  always #5 clk = ~clk;

  // Slave model for instance A: tdo is tdi delayed by one register.
  always @(posedge clk) a_tdo <= a_tdi;

  nios_dbg_scan_master u_a (
    .clk(clk), .reset(reset),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_ir(a_cmd_ir), .cmd_data(a_cmd_data),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data), .rsp_ir(a_rsp_ir),
    .ir_in(a_ir_in), .ir_out(a_ir_out),
    .vs_uir(a_vs_uir), .vs_cdr(a_vs_cdr), .vs_sdr(a_vs_sdr), .vs_udr(a_vs_udr),
    .jtag_state_rti(a_rti), .tdi(a_tdi), .tdo(a_tdo)
  );

  nios_dbg_scan_master #(.SR_WIDTH(2), .IDLE_CYCLES(0)) u_b (
    .clk(clk), .reset(reset),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_ir(b_cmd_ir), .cmd_data(b_cmd_data),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_ir(b_rsp_ir),
    .ir_in(b_ir_in), .ir_out(b_ir_out),
    .vs_uir(b_vs_uir), .vs_cdr(b_vs_cdr), .vs_sdr(b_vs_sdr), .vs_udr(b_vs_udr),
    .jtag_state_rti(b_rti), .tdi(b_tdi), .tdo(b_tdo)
  );

  // Expected capture with a one-register loopback: bit k sees tdi of the
  // previous cycle, and the first bit sees the idle tdi value 0.
  function automatic logic [37:0] loop_model(input logic [37:0] d);
    logic [37:0] e;
    logic        prev;
    prev = 1'b0;
    for (int k = 0; k < 38; k++) begin
      e[k] = prev;
      prev = d[k];
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({a_cmd_ready, a_rsp_valid, a_tdi, a_vs_uir, a_vs_cdr, a_vs_sdr, a_vs_udr, a_rti} !== 8'b1000_0001)
      begin errors++; $display("FAIL reset_ctrl_a: got %b want 10000001",
        {a_cmd_ready, a_rsp_valid, a_tdi, a_vs_uir, a_vs_cdr, a_vs_sdr, a_vs_udr, a_rti}); end
    checks++;
    if ({a_rsp_data, a_rsp_ir, a_ir_in} !== 42'd0)
      begin errors++; $display("FAIL reset_data_a: rsp_data=%h rsp_ir=%b ir_in=%b want 0", a_rsp_data, a_rsp_ir, a_ir_in); end
    checks++;
    if (u_a.bit_cnt !== 7'd0)
      begin errors++; $display("FAIL reset_bitcnt: got %0d want 0", u_a.bit_cnt); end
    checks++;
    if ({b_cmd_ready, b_rsp_valid, b_rti, b_rsp_data} !== 5'b10100)
      begin errors++; $display("FAIL reset_b: got %b want 10100", {b_cmd_ready, b_rsp_valid, b_rti, b_rsp_data}); end
    reset = 1'b0;
  endtask

  task automatic test_single_scan();
    logic [37:0] d;
    int n, sdr_k, n_uir, n_cdr, n_udr, n_rti;
    bit done, overlap, tdi_bad, ir_bad, gap;
    d = 38'h2A_5555_5555;
    n = 0; sdr_k = 0; n_uir = 0; n_cdr = 0; n_udr = 0; n_rti = 0;
    done = 0; overlap = 0; tdi_bad = 0; ir_bad = 0; gap = 0;
    a_cmd_ir = 2'b01; a_cmd_data = d; a_ir_out = 2'b10; a_rsp_ready = 1'b0; a_cmd_valid = 1'b1;
    step();
    a_cmd_valid = 1'b0; a_cmd_ir = 2'b00; a_cmd_data = '0;
    checks++;
    if ({a_vs_uir, a_cmd_ready} !== 2'b10)
      begin errors++; $display("FAIL first_accept: vs_uir,cmd_ready=%b want 10", {a_vs_uir, a_cmd_ready}); end
    while (!done && n < 200) begin
      if (a_rsp_valid === 1'b1) done = 1;
      else begin
        if ($countones({a_vs_uir, a_vs_cdr, a_vs_sdr, a_vs_udr, a_rti}) > 1) overlap = 1;
        n_uir += int'(a_vs_uir); n_cdr += int'(a_vs_cdr); n_udr += int'(a_vs_udr); n_rti += int'(a_rti);
        if (a_vs_sdr === 1'b1) begin
          if (sdr_k < 38 && a_tdi !== d[sdr_k]) tdi_bad = 1;
          if (n != 2 + sdr_k) gap = 1;
          sdr_k++;
        end else if (a_tdi !== 1'b0) tdi_bad = 1;
        if (n <= 40 && a_ir_in !== 2'b01) ir_bad = 1;
        step();
        n++;
      end
    end
    checks++;
    if (!done || n != 43) begin errors++; $display("FAIL scan_latency: got %0d want 43 (done=%0d)", n, done); end
    checks++;
    if ({n_uir, n_cdr, sdr_k, n_udr, n_rti} !== {32'd1, 32'd1, 32'd38, 32'd1, 32'd2})
      begin errors++; $display("FAIL strobe_counts: uir=%0d cdr=%0d sdr=%0d udr=%0d rti=%0d want 1 1 38 1 2",
        n_uir, n_cdr, sdr_k, n_udr, n_rti); end
    checks++;
    if ({overlap, gap} !== 2'b00) begin errors++; $display("FAIL strobe_overlap: overlap=%0d gap=%0d want 0 0", overlap, gap); end
    checks++;
    if (tdi_bad) begin errors++; $display("FAIL tdi_sequence: got mismatching bit want cmd_data LSB first"); end
    checks++;
    if (ir_bad) begin errors++; $display("FAIL ir_in_stable: got %b want 01", a_ir_in); end
    checks++;
    if (a_rsp_ir !== 2'b10) begin errors++; $display("FAIL scan_rsp_ir: got %b want 10", a_rsp_ir); end
    checks++;
    if (a_rsp_data !== loop_model(d))
      begin errors++; $display("FAIL scan_rsp_data: got %h want %h", a_rsp_data, loop_model(d)); end
    a_rsp_ready = 1'b1;
    step();
    a_rsp_ready = 1'b0;
    checks++;
    if ({a_rsp_valid, a_cmd_ready, a_rti} !== 3'b011)
      begin errors++; $display("FAIL scan_handshake: rsp_valid,cmd_ready,rti=%b want 011", {a_rsp_valid, a_cmd_ready, a_rti}); end
  endtask

  task automatic test_back_to_back();
    logic [37:0] d2, d3, held;
    int n;
    bit bad;
    d2 = 38'h0F_F00F_3C5A;
    d3 = 38'h31_2345_6789;
    a_cmd_ir = 2'b10; a_cmd_data = d2; a_ir_out = 2'b11; a_cmd_valid = 1'b1;
    step();
    n = 0;
    while (a_rsp_valid !== 1'b1 && n < 200) begin step(); n++; end
    checks++;
    if (n != 43) begin errors++; $display("FAIL bp_latency: got %0d want 43", n); end
    held = a_rsp_data;
    checks++;
    if (held !== loop_model(d2)) begin errors++; $display("FAIL bp_rsp_data: got %h want %h", held, loop_model(d2)); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (a_rsp_data !== held || a_rsp_valid !== 1'b1 || a_cmd_ready !== 1'b0 || a_rsp_ir !== 2'b11) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL bp_hold: rsp_data=%h cmd_ready=%b want %h and 0", a_rsp_data, a_cmd_ready, held); end
    a_cmd_data = d3; a_cmd_ir = 2'b01; a_ir_out = 2'b01; a_rsp_ready = 1'b1;
    step();
    a_rsp_ready = 1'b0;
    checks++;
    if ({a_cmd_ready, a_vs_uir, a_rsp_valid} !== 3'b100)
      begin errors++; $display("FAIL b2b_no_same_edge: cmd_ready,vs_uir,rsp_valid=%b want 100", {a_cmd_ready, a_vs_uir, a_rsp_valid}); end
    step();
    a_cmd_valid = 1'b0;
    checks++;
    if ({a_cmd_ready, a_vs_uir, a_ir_in} !== 4'b0101)
      begin errors++; $display("FAIL b2b_accept: cmd_ready,vs_uir,ir_in=%b want 0101", {a_cmd_ready, a_vs_uir, a_ir_in}); end
    n = 0;
    while (a_rsp_valid !== 1'b1 && n < 200) begin step(); n++; end
    checks++;
    if (n != 43 || a_rsp_data !== loop_model(d3) || a_rsp_ir !== 2'b01)
      begin errors++; $display("FAIL b2b_second: lat=%0d data=%h ir=%b want 43 %h 01", n, a_rsp_data, a_rsp_ir, loop_model(d3)); end
    a_rsp_ready = 1'b1;
    step();
    a_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_sdr();
    logic [37:0] d4;
    int n;
    bit seen;
    a_cmd_ir = 2'b11; a_cmd_data = 38'h15_AAAA_0001; a_ir_out = 2'b01; a_cmd_valid = 1'b1;
    step();
    a_cmd_valid = 1'b0;
    for (int i = 0; i < 21; i++) step();
    checks++;
    if (a_vs_sdr !== 1'b1) begin errors++; $display("FAIL abort_in_sdr: vs_sdr=%b want 1", a_vs_sdr); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({a_vs_uir, a_vs_cdr, a_vs_sdr, a_vs_udr, a_tdi, a_cmd_ready, a_rsp_valid, a_rti} !== 8'b0000_0101)
      begin errors++; $display("FAIL abort_state: got %b want 00000101",
        {a_vs_uir, a_vs_cdr, a_vs_sdr, a_vs_udr, a_tdi, a_cmd_ready, a_rsp_valid, a_rti}); end
    checks++;
    if ({a_ir_in, a_rsp_ir, u_a.bit_cnt} !== 11'd0)
      begin errors++; $display("FAIL abort_regs: ir_in=%b rsp_ir=%b bit_cnt=%0d want 0", a_ir_in, a_rsp_ir, u_a.bit_cnt); end
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (a_rsp_valid !== 1'b0 || a_vs_sdr !== 1'b0) seen = 1;
      step();
    end
    checks++;
    if (seen) begin errors++; $display("FAIL abort_no_rsp: got activity after abort want none"); end
    d4 = 38'h2C_0FF0_A5C3;
    a_cmd_ir = 2'b10; a_cmd_data = d4; a_ir_out = 2'b10; a_cmd_valid = 1'b1;
    step();
    a_cmd_valid = 1'b0;
    n = 0;
    while (a_rsp_valid !== 1'b1 && n < 200) begin step(); n++; end
    checks++;
    if (n != 43 || a_rsp_data !== loop_model(d4) || a_rsp_ir !== 2'b10)
      begin errors++; $display("FAIL abort_fresh: lat=%0d data=%h ir=%b want 43 %h 10", n, a_rsp_data, a_rsp_ir, loop_model(d4)); end
    a_rsp_ready = 1'b1;
    step();
    a_rsp_ready = 1'b0;
  endtask

  task automatic test_short_scan();
    int n;
    bit rti_seen, tdi_bad;
    b_cmd_ir = 2'b11; b_cmd_data = 2'b10; b_ir_out = 2'b01; b_cmd_valid = 1'b1;
    step();
    b_cmd_valid = 1'b0;
    n = 0; rti_seen = 0; tdi_bad = 0;
    while (b_rsp_valid !== 1'b1 && n < 50) begin
      if (b_rti !== 1'b0) rti_seen = 1;
      if (n == 2 && {b_vs_sdr, b_tdi} !== 2'b10) tdi_bad = 1;
      if (n == 3 && {b_vs_sdr, b_tdi} !== 2'b11) tdi_bad = 1;
      if (n != 2 && n != 3 && b_tdi !== 1'b0) tdi_bad = 1;
      step();
      n++;
    end
    checks++;
    if (n != 5) begin errors++; $display("FAIL short_latency: got %0d want 5", n); end
    checks++;
    if (rti_seen) begin errors++; $display("FAIL short_no_rti: got rti=1 want 0"); end
    checks++;
    if (tdi_bad) begin errors++; $display("FAIL short_tdi: got wrong tdi want 0 then 1"); end
    checks++;
    if ({b_rsp_data, b_rsp_ir} !== 4'b1101)
      begin errors++; $display("FAIL short_rsp: data=%b ir=%b want 11 01", b_rsp_data, b_rsp_ir); end
    b_rsp_ready = 1'b1;
    step();
    b_rsp_ready = 1'b0;
    checks++;
    if ({b_rsp_valid, b_cmd_ready, b_rti} !== 3'b011)
      begin errors++; $display("FAIL short_handshake: got %b want 011", {b_rsp_valid, b_cmd_ready, b_rti}); end
  endtask

  initial begin
    test_reset();
    test_single_scan();
    test_back_to_back();
    test_reset_mid_sdr();
    test_short_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
